// File: rtl/pin_pulse_driver.sv
// pin_pulse_driver: turns single-cycle trigger strobes into timed pin pulses followed by a fixed low gap,
// queueing extra requests in a saturating counter. Define PIN_INVERT_EN for an active-low pin.
module pin_pulse_driver #(
  parameter int unsigned SYSCLOCK_FREQ = 100_000_000,
  parameter int unsigned HIGH_PERIOD   = SYSCLOCK_FREQ / 200,
  parameter int unsigned GAP_PERIOD    = SYSCLOCK_FREQ / 200,
  parameter int unsigned PEND_W        = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              trigger,
  output logic              pin,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [31:0]       HIGH_LOAD = 32'(HIGH_PERIOD);
  localparam logic [31:0]       GAP_LOAD  = 32'(GAP_PERIOD);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

`ifdef PIN_INVERT_EN
  localparam logic PIN_IDLE = 1'b1;
`else
  localparam logic PIN_IDLE = 1'b0;
`endif
  localparam logic PIN_ACTIVE = ~PIN_IDLE;

  generate
    if (HIGH_PERIOD < 1) begin : g_bad_high
      $error("pin_pulse_driver: HIGH_PERIOD must be >= 1");
    end
    if (GAP_PERIOD < 1) begin : g_bad_gap
      $error("pin_pulse_driver: GAP_PERIOD must be >= 1");
    end
    if (PEND_W < 1) begin : g_bad_pend
      $error("pin_pulse_driver: PEND_W must be >= 1");
    end
  endgenerate

  state_t            state_q;
  logic [31:0]       cnt_q;
  logic              pin_q;
  logic              busy_q;
  logic [PEND_W-1:0] pending_q;
  logic              overflow_q;

  // A request arriving while busy either queues or, when the queue is full, is dropped.
  logic              pend_full;
  logic [PEND_W-1:0] pend_enq_d;
  logic              drop_d;
  logic              cnt_last;

  always_comb begin
    pend_full  = (pending_q == PEND_MAX);
    drop_d     = trigger & pend_full;
    pend_enq_d = pending_q;
    if (trigger && !pend_full) begin
      pend_enq_d = pending_q + PEND_ONE;
    end
    cnt_last = (cnt_q == 32'd1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      pin_q      <= PIN_IDLE;
      busy_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            state_q <= S_HIGH;
            pin_q   <= PIN_ACTIVE;
            busy_q  <= 1'b1;
            cnt_q   <= HIGH_LOAD;
          end
        end

        S_HIGH: begin
          pending_q  <= pend_enq_d;
          overflow_q <= drop_d;
          if (cnt_last) begin
            state_q <= S_GAP;
            pin_q   <= PIN_IDLE;
            cnt_q   <= GAP_LOAD;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end

        S_GAP: begin
          if (cnt_last) begin
            // Exit edge: a same-edge trigger is served directly rather than queued.
            if ((pending_q != '0) || trigger) begin
              state_q <= S_HIGH;
              pin_q   <= PIN_ACTIVE;
              cnt_q   <= HIGH_LOAD;
              if ((pending_q != '0) && !trigger) begin
                pending_q <= pending_q - PEND_ONE;
              end
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              cnt_q   <= 32'd0;
            end
          end else begin
            cnt_q      <= cnt_q - 32'd1;
            pending_q  <= pend_enq_d;
            overflow_q <= drop_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
          pin_q   <= PIN_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 32'd0;
        end
      endcase
    end
  end

  assign pin      = pin_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pin_pulse_driver.sv
// Bench for pin_pulse_driver: a pulse-timeline model feeds a per-edge scoreboard of expected outputs.
module tb_pin_pulse_driver;

  localparam int H    = 4;
  localparam int G    = 3;
  localparam int PW   = 2;
  localparam int MAXP = 3;

`ifdef PIN_INVERT_EN
  localparam logic PIN_IDLE = 1'b1;
`else
  localparam logic PIN_IDLE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          trigger = 1'b0;
  logic          pin;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  pin_pulse_driver #(
    .HIGH_PERIOD (H),
    .GAP_PERIOD  (G),
    .PEND_W      (PW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .trigger  (trigger),
    .pin      (pin),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            edge_n;
    logic          pin;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   trig_q[$];
  int   st_q[$];
  int   tg_q[$];
  int   drop_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses are scheduled on a timeline: a request starts at its own edge or at the exit edge of the last pulse.
  task automatic build_schedule();
    st_q.delete();
    tg_q.delete();
    drop_q.delete();
    foreach (trig_q[j]) begin
      int t;
      int e;
      int cnt;
      t = trig_q[j];
      e = (st_q.size() == 0) ? -1000 : st_q[st_q.size()-1] + H + G;
      if (t < e) begin
        cnt = 0;
        foreach (st_q[i]) if (st_q[i] > t) cnt++;
        if (cnt >= MAXP) begin
          drop_q.push_back(t);
          $display("req @%0d: dropped (queue full)", t);
        end else begin
          st_q.push_back(e);
          tg_q.push_back(t);
          $display("req @%0d: queued, pulse starts @%0d", t, e);
        end
      end else begin
        st_q.push_back(t);
        tg_q.push_back(t);
        $display("req @%0d: pulse starts @%0d", t, t);
      end
    end
  endtask

  function automatic exp_t model_at(input int k);
    exp_t r;
    r.edge_n = k;
    r.pin    = 1'b0;
    r.busy   = 1'b0;
    r.pend   = '0;
    r.ovf    = 1'b0;
    foreach (st_q[i]) begin
      if (st_q[i] <= k && k <= st_q[i] + H - 1)     r.pin = 1'b1;
      if (st_q[i] <= k && k <= st_q[i] + H + G - 1) r.busy = 1'b1;
      if (tg_q[i] <= k && st_q[i] > k)              r.pend = r.pend + 1'b1;
    end
    foreach (drop_q[i]) if (drop_q[i] == k) r.ovf = 1'b1;
    r.pin = r.pin ^ PIN_IDLE;
    return r;
  endfunction

  task automatic compare_front(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({name, " sb_underflow"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val($sformatf("%s e%0d pin", name, e.edge_n), 32'(pin), 32'(e.pin));
    check_val($sformatf("%s e%0d busy", name, e.edge_n), 32'(busy), 32'(e.busy));
    check_val($sformatf("%s e%0d pending", name, e.edge_n), 32'(pending), 32'(e.pend));
    check_val($sformatf("%s e%0d overflow", name, e.edge_n), 32'(overflow), 32'(e.ovf));
  endtask

  task automatic idle_check(input string tag);
    check_val({tag, " pin"}, 32'(pin), 32'(PIN_IDLE));
    check_val({tag, " busy"}, 32'(busy), 32'd0);
    check_val({tag, " pending"}, 32'(pending), 32'd0);
    check_val({tag, " overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic run_scenario(input string name, input int n_edges, input int abort_edge);
    exp_t z;
    $display("scenario %s", name);
    @(negedge clk);
    resetn  = 1'b0;
    trigger = 1'b1;
    #1;
    idle_check({name, " async_rst_in"});
    repeat (2) @(negedge clk);
    idle_check({name, " in_rst"});
    trigger = 1'b0;
    resetn  = 1'b1;
    build_schedule();
    for (int k = 1; k <= n_edges; k++) begin
      trigger = 1'b0;
      foreach (trig_q[j]) if (trig_q[j] == k) trigger = 1'b1;
      exp_q.push_back(model_at(k));
      @(posedge clk);
      #1;
      compare_front(name);
      if (k == abort_edge) break;
      @(negedge clk);
    end
    trigger = 1'b0;
    if (abort_edge > 0) begin
      #2;
      resetn = 1'b0;
      #1;
      idle_check({name, " mid_abort"});
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      for (int k = 1; k <= 30; k++) begin
        z.edge_n = k;
        z.pin    = PIN_IDLE;
        z.busy   = 1'b0;
        z.pend   = '0;
        z.ovf    = 1'b0;
        exp_q.push_back(z);
        @(posedge clk);
        #1;
        compare_front({name, "_post"});
        @(negedge clk);
      end
    end
    check_val({name, " sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    trig_q = '{10};
    run_scenario("single", 22, 0);
    trig_q = '{10, 11, 12};
    run_scenario("three", 36, 0);
    trig_q = '{10, 11, 12, 13, 14};
    run_scenario("overflow", 42, 0);
    trig_q = '{10, 17};
    run_scenario("exit_direct", 30, 0);
    trig_q = '{10, 11, 17};
    run_scenario("exit_with_pend", 36, 0);
    trig_q = '{10, 15, 25};
    run_scenario("gap_req_retrig", 36, 0);
    trig_q = '{10, 11};
    run_scenario("abort", 20, 12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
